// File: rtl/wave_rom_gen.sv
// rtl/wave_rom_gen.sv - waveform sample source with quarter-wave sine, shapes and deferred gain
// Two-stage pipeline: stage 1 builds the raw sample, stage 2 applies the gain.
// Waveform/gain changes are staged and committed only when the phase wraps to 0.
module wave_rom_gen #(
   parameter logic [1:0] WAVE_DEFAULT = 2'd0,
   parameter logic [7:0] AMP_DEFAULT  = 8'd255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   input  logic [1:0] wave_sel,
   input  logic [7:0] amp,
   input  logic       cfg_load,
   output logic       cfg_busy,
   output logic [1:0] wave_active
);

   localparam logic [1:0] WAVE_SINE = 2'd0;
   localparam logic [1:0] WAVE_TRI  = 2'd1;
   localparam logic [1:0] WAVE_SQR  = 2'd2;

   // Quarter-wave sine magnitude, sampled at bin centres so the four
   // quadrants mirror cleanly without duplicating the peak or the zero.
   function automatic logic [6:0] quarter_sine(input logic [5:0] idx);
      logic [6:0] q;
      q = 7'd0;
      case (idx)
         6'd0:  q = 7'd2;    6'd1:  q = 7'd5;    6'd2:  q = 7'd8;    6'd3:  q = 7'd11;
         6'd4:  q = 7'd14;   6'd5:  q = 7'd17;   6'd6:  q = 7'd20;   6'd7:  q = 7'd23;
         6'd8:  q = 7'd26;   6'd9:  q = 7'd29;   6'd10: q = 7'd32;   6'd11: q = 7'd35;
         6'd12: q = 7'd38;   6'd13: q = 7'd41;   6'd14: q = 7'd44;   6'd15: q = 7'd47;
         6'd16: q = 7'd50;   6'd17: q = 7'd53;   6'd18: q = 7'd56;   6'd19: q = 7'd58;
         6'd20: q = 7'd61;   6'd21: q = 7'd64;   6'd22: q = 7'd67;   6'd23: q = 7'd69;
         6'd24: q = 7'd72;   6'd25: q = 7'd74;   6'd26: q = 7'd77;   6'd27: q = 7'd79;
         6'd28: q = 7'd82;   6'd29: q = 7'd84;   6'd30: q = 7'd86;   6'd31: q = 7'd89;
         6'd32: q = 7'd91;   6'd33: q = 7'd93;   6'd34: q = 7'd95;   6'd35: q = 7'd97;
         6'd36: q = 7'd99;   6'd37: q = 7'd101;  6'd38: q = 7'd103;  6'd39: q = 7'd105;
         6'd40: q = 7'd106;  6'd41: q = 7'd108;  6'd42: q = 7'd110;  6'd43: q = 7'd111;
         6'd44: q = 7'd113;  6'd45: q = 7'd114;  6'd46: q = 7'd115;  6'd47: q = 7'd117;
         6'd48: q = 7'd118;  6'd49: q = 7'd119;  6'd50: q = 7'd120;  6'd51: q = 7'd121;
         6'd52: q = 7'd122;  6'd53: q = 7'd123;  6'd54: q = 7'd124;  6'd55: q = 7'd124;
         6'd56: q = 7'd125;  6'd57: q = 7'd125;  6'd58: q = 7'd126;  6'd59: q = 7'd126;
         6'd60: q = 7'd127;  6'd61: q = 7'd127;  6'd62: q = 7'd127;  6'd63: q = 7'd127;
         default: q = 7'd0;
      endcase
      return q;
   endfunction

   // Configuration state: committed (active) and staged (pending) copies
   logic [1:0] act_wave_q;
   logic [7:0] act_amp_q;
   logic [1:0] pend_wave_q;
   logic [7:0] pend_amp_q;
   logic       cfg_busy_q;

   // Pipeline registers
   logic [7:0] raw_q;
   logic [7:0] amp_s1_q;
   logic [7:0] data_q;

   // Stage-1 combinational signals
   logic       applying;
   logic [1:0] eff_wave;
   logic [7:0] eff_amp;
   logic [5:0] q_idx;
   logic [6:0] q_val;
   logic [7:0] raw_d;

   // Stage-2 combinational signals
   logic signed [8:0]  centred;
   logic signed [9:0]  gain;
   logic signed [17:0] product;
   logic [7:0]         data_d;

   // Commit point: staged config takes effect on the wrap-to-zero sample,
   // unless a fresh load lands on that same cycle (it then waits a full period).
   always_comb begin
      applying = cfg_busy_q && (rd_addr == 8'd0) && !cfg_load;
      eff_wave = applying ? pend_wave_q : act_wave_q;
      eff_amp  = applying ? pend_amp_q  : act_amp_q;
   end

   // Stage 1 raw sample generation for the selected waveform
   always_comb begin
      q_idx = rd_addr[6] ? ~rd_addr[5:0] : rd_addr[5:0];
      q_val = quarter_sine(q_idx);
      raw_d = 8'd128;
      case (eff_wave)
         WAVE_SINE: raw_d = rd_addr[7] ? (8'd127 - {1'b0, q_val}) : (8'd128 + {1'b0, q_val});
         WAVE_TRI:  raw_d = rd_addr[7] ? {~rd_addr[6:0], 1'b1} : {rd_addr[6:0], 1'b0};
         WAVE_SQR:  raw_d = rd_addr[7] ? 8'd0 : 8'd255;
         default:   raw_d = rd_addr;
      endcase
   end

   // Stage 2 gain: scale the signed offset from mid-scale by (amp+1)/256, floor
   always_comb begin
      centred = $signed({1'b0, raw_q} - 9'd128);
      gain    = $signed({1'b0, ({1'b0, amp_s1_q} + 9'd1)});
      product = 18'(centred) * 18'(gain);
      data_d  = 8'(product >>> 8) + 8'd128;
   end

   // Configuration capture and deferred commit
   always_ff @(posedge clk) begin
      if (rst) begin
         act_wave_q  <= WAVE_DEFAULT;
         act_amp_q   <= AMP_DEFAULT;
         pend_wave_q <= WAVE_DEFAULT;
         pend_amp_q  <= AMP_DEFAULT;
         cfg_busy_q  <= 1'b0;
      end else if (cfg_load) begin
         pend_wave_q <= wave_sel;
         pend_amp_q  <= amp;
         cfg_busy_q  <= 1'b1;
      end else if (applying) begin
         act_wave_q  <= pend_wave_q;
         act_amp_q   <= pend_amp_q;
         cfg_busy_q  <= 1'b0;
      end
   end

   // Sample pipeline; gain travels with its sample so a commit never splits a sample
   always_ff @(posedge clk) begin
      if (rst) begin
         raw_q    <= 8'd128;
         amp_s1_q <= AMP_DEFAULT;
         data_q   <= 8'd128;
      end else begin
         raw_q    <= raw_d;
         amp_s1_q <= eff_amp;
         data_q   <= data_d;
      end
   end

   assign rd_data     = data_q;
   assign cfg_busy    = cfg_busy_q;
   assign wave_active = act_wave_q;

endmodule

// File: doc/wave_rom_gen.md
Name: wave_rom_gen

Overview:
Waveform sample source that sits directly upstream of the DA wave sender. It replaces the plain 256-entry waveform ROM and keeps the same read contract: the sender drives an 8-bit phase address and receives an 8-bit unsigned sample. It generates sine (from a quarter-wave table), triangle, square and sawtooth samples, then scales them by a run-time gain. Waveform and gain changes are deferred to the phase wrap at address 0, so every output period stays glitch-free.

Parameters:
WAVE_DEFAULT, 2'd0, waveform selected after reset (0 sine, 1 triangle, 2 square, 3 sawtooth)
AMP_DEFAULT, 8'd255, amplitude code after reset (255 gives unity gain)

Ports:
clk  input  1  system clock; the only clock domain
rst  input  1  synchronous reset, active-high
rd_addr  input  8  phase address from the DA wave sender
rd_data  output  8  unsigned sample to the sender; mid-scale is 128
wave_sel  input  2  requested waveform; sampled on cfg_load
amp  input  8  requested amplitude code; gain g = amp+1 (range 1..256); sampled on cfg_load
cfg_load  input  1  one-cycle strobe that captures wave_sel and amp into the pending registers
cfg_busy  output  1  high while a captured configuration waits for the next phase wrap
wave_active  output  2  waveform currently in use

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state is updated on the rising edge of clk.
- Reset values:
  - rd_data = 8'd128; the internal stage-1 sample register = 8'd128.
  - cfg_busy = 0.
  - wave_active = WAVE_DEFAULT; active amp = AMP_DEFAULT; pending registers take the same default values.
- Reset mid-operation: everything above is restored on the next edge, and any pending configuration is discarded.
- Pipeline: 2-cycle latency. rd_addr presented at edge N produces rd_data valid after edge N+2. The pipeline runs every cycle; there is no stall and no valid signal.
- Stage 1 computes the raw sample from rd_addr, with a = rd_addr[5:0]:
  - Sine uses a 64-entry quarter table Q[i] = round(127*sin(2*pi*(i+0.5)/256)), i = 0..63, so Q[0] = 2 and Q[63] = 127.
  - Sine by quadrant rd_addr[7:6]:
    - 00: 128 + Q[a]
    - 01: 128 + Q[~a]
    - 10: 127 - Q[a]
    - 11: 127 - Q[~a]
  - Triangle:
    - rd_addr[7] = 0: {rd_addr[6:0], 1'b0}
    - rd_addr[7] = 1: {~rd_addr[6:0], 1'b1}
  - Square: rd_addr[7] ? 0 : 255.
  - Sawtooth: rd_addr.
- Stage 1 also registers the active amp alongside the sample, so each sample is scaled with the gain that was in force when it entered the pipeline.
- Stage 2 scales the sample:
  - s = raw - 128, as a signed 9-bit value.
  - p = s * (amp+1), as a signed 18-bit value.
  - rd_data = 128 + (p >>> 8), using an arithmetic shift (floor).
  - amp = 255 gives exact passthrough; no saturation logic is needed.
- Configuration:
  - On cfg_load, pending <= {wave_sel, amp} and cfg_busy <= 1.
  - Application happens on a cycle where cfg_busy = 1, rd_addr == 0 and cfg_load = 0. On that cycle, active <= pending and cfg_busy <= 0 on the same edge. That address-0 sample is already computed with the new configuration, because stage 1 selects pending when applying.
  - cfg_load while busy: pending is overwritten (last load wins); cfg_busy stays 1.
  - cfg_load coincident with rd_addr == 0: the new values go to pending and application defers to the next wrap to address 0. The sample for this address uses the old configuration.
  - The sender holds rd_addr for several cycles. Only the first qualifying cycle applies; later cycles see cfg_busy = 0 and do nothing.
- wave_active reflects the active waveform from the edge of application.

Test Plan:
1. Reset; defaults (sine, amp 255). Drive addr 0, 64, 128, 192 -> rd_data 130, 255, 125, 0, each 2 cycles after its address.
2. cfg_load wave_sel=1, then wrap to address 0. Drive addr 127, 128, 255 -> rd_data 254, 255, 1.
3. Square with amp=127: addr 0 -> 191; addr 128 -> 64. Then amp=0: addr 0 -> 128; addr 128 -> 127.
4. Sine running, addr at 100. Pulse cfg_load with sawtooth -> cfg_busy=1 and sine output continues. At addr 0: cfg_busy drops after that edge, wave_active=3, rd_data for addr 0 = 0, and addr 5 -> 5.
5. Two cfg_loads while busy (triangle, then square) -> square applied at the wrap. Then cfg_load coincident with addr 0 -> no change at that address, cfg_busy=1 until the next address 0.
6. Assert rst mid-stream with cfg_busy=1 -> next edge: rd_data=128, cfg_busy=0, wave_active=WAVE_DEFAULT. Then addr 64 -> 255 after 2 cycles.
